// File: rtl/twi_master.sv
// twi_master: single-register I2C write/read master for board device setup.
// Open-drain SDA/SCL drives sequenced in four-quarter bus slots.
`timescale 1ns/1ps
module twi_master #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       i_system_clk,
    input  logic       i_system_rst,
    input  logic       i_start,
    input  logic       i_rnw,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    input  logic       i_sda,
    output logic       o_sda,
    input  logic       i_scl,
    output logic       o_scl
);

    typedef enum logic [2:0] {
        IDLE, START, TX_BIT, RX_ACK, RSTART, RX_BIT, TX_NACK, STOP
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

    localparam logic [1:0] SEL_AW   = 2'd0;
    localparam logic [1:0] SEL_REG  = 2'd1;
    localparam logic [1:0] SEL_DATA = 2'd2;
    localparam logic [1:0] SEL_AR   = 2'd3;

    state_t      state;
    logic [1:0]  q;
    logic [15:0] cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_sel;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_sh;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic [6:0]  dev_q;
    logic        rnw_q;
    logic        sda_smp;

    // Pin levels {sda, scl} for a given slot type and quarter.
    function automatic logic [1:0] pins(input state_t st,
                                        input logic [1:0] qq,
                                        input logic b);
        logic [1:0] p;
        p = 2'b11;
        unique case (st)
            IDLE:    p = 2'b11;
            START:   p = {~qq[1], qq != 2'd3};
            RSTART:  p = {~qq[1], qq == 2'd1 || qq == 2'd2};
            STOP:    p = {qq[1], qq != 2'd0};
            TX_BIT:  p = {b, qq[1]};
            RX_ACK:  p = {1'b1, qq[1]};
            RX_BIT:  p = {1'b1, qq[1]};
            TX_NACK: p = {1'b1, qq[1]};
        endcase
        return p;
    endfunction

    always_ff @(posedge i_system_clk or posedge i_system_rst) begin
        if (i_system_rst) begin
            state     <= IDLE;
            q         <= 2'd0;
            cnt       <= '0;
            bit_cnt   <= '0;
            byte_sel  <= SEL_AW;
            tx_byte   <= '0;
            rx_sh     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            dev_q     <= '0;
            rnw_q     <= 1'b0;
            sda_smp   <= 1'b1;
            o_rdata   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_ack_err <= 1'b0;
            o_sda     <= 1'b1;
            o_scl     <= 1'b1;
        end else begin
            o_done <= 1'b0;
            if (state == IDLE) begin
                if (i_start) begin
                    rnw_q     <= i_rnw;
                    dev_q     <= i_dev_addr;
                    reg_q     <= i_reg_addr;
                    wdata_q   <= i_wdata;
                    tx_byte   <= {i_dev_addr, 1'b0};
                    byte_sel  <= SEL_AW;
                    bit_cnt   <= '0;
                    q         <= 2'd0;
                    cnt       <= '0;
                    o_busy    <= 1'b1;
                    o_ack_err <= 1'b0;
                    state     <= START;
                    {o_sda, o_scl} <= pins(START, 2'd0, 1'b1);
                end
            end else if (q == 2'd2 && !i_scl) begin
                // slave stretching: q2 only counts once SCL is seen high
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= '0;
                if (q == 2'd2) begin
                    sda_smp <= i_sda;
                    if (state == RX_BIT)
                        rx_sh <= {rx_sh[6:0], i_sda};
                end
                if (q != 2'd3) begin
                    q <= q + 2'd1;
                    {o_sda, o_scl} <= pins(state, q + 2'd1, tx_byte[7]);
                end else begin
                    q <= 2'd0;
                    unique case (state)
                        START: begin
                            state <= TX_BIT;
                            {o_sda, o_scl} <= {tx_byte[7], 1'b0};
                        end
                        RSTART: begin
                            state    <= TX_BIT;
                            tx_byte  <= {dev_q, 1'b1};
                            byte_sel <= SEL_AR;
                            {o_sda, o_scl} <= {dev_q[6], 1'b0};
                        end
                        TX_BIT: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= RX_ACK;
                                {o_sda, o_scl} <= 2'b10;
                            end else begin
                                tx_byte <= {tx_byte[6:0], 1'b0};
                                {o_sda, o_scl} <= {tx_byte[6], 1'b0};
                            end
                        end
                        RX_ACK: begin
                            if (sda_smp) begin
                                o_ack_err <= 1'b1;
                                state     <= STOP;
                                {o_sda, o_scl} <= 2'b00;
                            end else begin
                                unique case (byte_sel)
                                    SEL_AW: begin
                                        state    <= TX_BIT;
                                        tx_byte  <= reg_q;
                                        byte_sel <= SEL_REG;
                                        {o_sda, o_scl} <= {reg_q[7], 1'b0};
                                    end
                                    SEL_REG: begin
                                        if (rnw_q) begin
                                            state <= RSTART;
                                            {o_sda, o_scl} <= 2'b10;
                                        end else begin
                                            state    <= TX_BIT;
                                            tx_byte  <= wdata_q;
                                            byte_sel <= SEL_DATA;
                                            {o_sda, o_scl} <= {wdata_q[7], 1'b0};
                                        end
                                    end
                                    SEL_DATA: begin
                                        state <= STOP;
                                        {o_sda, o_scl} <= 2'b00;
                                    end
                                    SEL_AR: begin
                                        state <= RX_BIT;
                                        {o_sda, o_scl} <= 2'b10;
                                    end
                                endcase
                            end
                        end
                        RX_BIT: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            {o_sda, o_scl} <= 2'b10;
                            if (bit_cnt == 3'd7) begin
                                o_rdata <= rx_sh;
                                state   <= TX_NACK;
                            end
                        end
                        TX_NACK: begin
                            state <= STOP;
                            {o_sda, o_scl} <= 2'b00;
                        end
                        STOP: begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            {o_sda, o_scl} <= 2'b11;
                        end
                        IDLE: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_twi_master.sv
// tb_twi_master: table-driven bench with an I2C slave model and bus scoreboard.
// Expected bus events are queued at issue and popped as the monitor decodes them.
`timescale 1ns/1ps
module tb_twi_master;

    localparam int CLK_DIV = 4;
    localparam logic [6:0] SLV = 7'h76;
    localparam int EV_START  = 1000;
    localparam int EV_RSTART = 1001;
    localparam int EV_STOP   = 1002;

    typedef struct {
        logic       rnw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       stretch;
        int         lat;
        logic       err;
        logic       chk_rd;
        logic [7:0] rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_rnw = 1'b0;
    logic [6:0] i_dev_addr = '0;
    logic [7:0] i_reg_addr = '0;
    logic [7:0] i_wdata = '0;
    logic [7:0] o_rdata;
    logic       o_busy, o_done, o_ack_err;
    logic       o_sda, o_scl;
    logic       sl_sda = 1'b1;
    logic       hold = 1'b0;
    logic       sda_line, scl_line;
    logic       stretch_en = 1'b0;
    logic [7:0] slave_data = 8'h95;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t_acc = 0;
    int exp_q[$];
    vec_t tbl[5];

    int         m_bitcnt, m_byte, m_hcnt;
    logic [7:0] m_sh;
    logic       m_ps, m_pd, m_busy, m_addr, m_tx;

    assign sda_line = o_sda & sl_sda;
    assign scl_line = o_scl & ~hold;

    twi_master #(.CLK_DIV(CLK_DIV)) dut (
        .i_system_clk(clk),
        .i_system_rst(rst),
        .i_start(i_start),
        .i_rnw(i_rnw),
        .i_dev_addr(i_dev_addr),
        .i_reg_addr(i_reg_addr),
        .i_wdata(i_wdata),
        .o_rdata(o_rdata),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_ack_err(o_ack_err),
        .i_sda(sda_line),
        .o_sda(o_sda),
        .i_scl(scl_line),
        .o_scl(o_scl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_obs(input int ev);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL bus_event: unexpected event 0x%0h", ev);
        end else begin
            check("bus_event", ev, exp_q.pop_front());
        end
    endtask

    // Slave model and bus decoder; bytes are reported as {ack, data}.
    initial begin : monitor
        logic s, d;
        forever begin
            @(negedge clk);
            s = scl_line;
            d = sda_line;
            if (rst) begin
                m_ps = 1'b1; m_pd = 1'b1; m_busy = 1'b0; m_addr = 1'b0;
                m_tx = 1'b0; m_bitcnt = 0; m_byte = 0; m_hcnt = 0;
                m_sh = '0; sl_sda = 1'b1; hold = 1'b0;
            end else begin
                if (hold && o_scl) begin
                    m_hcnt++;
                    if (m_hcnt == 38) hold = 1'b0;
                end
                if (m_ps && s && m_pd && !d) begin
                    push_obs(m_busy ? EV_RSTART : EV_START);
                    m_busy = 1'b1; m_bitcnt = 0; m_byte = 0;
                    m_tx = 1'b0; sl_sda = 1'b1;
                end else if (m_ps && s && !m_pd && d) begin
                    push_obs(EV_STOP);
                    m_busy = 1'b0; m_bitcnt = 0; m_tx = 1'b0;
                    m_addr = 1'b0; sl_sda = 1'b1;
                end else if (!m_ps && s) begin
                    if (m_bitcnt < 8) begin
                        m_sh = {m_sh[6:0], d};
                        m_bitcnt++;
                    end else begin
                        push_obs(int'({d, m_sh}));
                        if (m_byte == 0 && !d && m_sh[0]) m_tx = 1'b1;
                        else if (m_tx && d) m_tx = 1'b0;
                        m_bitcnt = 0;
                        m_byte++;
                    end
                end else if (m_ps && !s) begin
                    if (m_bitcnt == 8) begin
                        if (m_tx) begin
                            sl_sda = 1'b1;
                        end else begin
                            if (m_byte == 0) m_addr = (m_sh[7:1] == SLV);
                            sl_sda = !m_addr;
                            if (stretch_en && m_byte == 1 && m_addr) begin
                                hold = 1'b1;
                                m_hcnt = 0;
                            end
                        end
                    end else if (m_tx) begin
                        sl_sda = slave_data[7 - m_bitcnt];
                    end else begin
                        sl_sda = 1'b1;
                    end
                end
                m_ps = s;
                m_pd = d;
            end
        end
    end

    task automatic push_expected(input vec_t v);
        logic nack;
        nack = (v.dev != SLV);
        exp_q.push_back(EV_START);
        exp_q.push_back(int'({nack, v.dev, 1'b0}));
        if (nack) begin
            exp_q.push_back(EV_STOP);
        end else begin
            exp_q.push_back(int'({1'b0, v.rg}));
            if (!v.rnw) begin
                exp_q.push_back(int'({1'b0, v.wd}));
            end else begin
                exp_q.push_back(EV_RSTART);
                exp_q.push_back(int'({1'b0, v.dev, 1'b1}));
                exp_q.push_back(int'({1'b1, slave_data}));
            end
            exp_q.push_back(EV_STOP);
        end
    endtask

    task automatic issue(input vec_t v);
        i_start    = 1'b1;
        i_rnw      = v.rnw;
        i_dev_addr = v.dev;
        i_reg_addr = v.rg;
        i_wdata    = v.wd;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        t_acc = cyc;
        check("busy_after_accept", o_busy, 1);
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_done && n < 3000);
        if (!o_done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no o_done after %0d cycles", n);
        end
        lat = cyc - t_acc;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int lat;
        push_expected(v);
        stretch_en = v.stretch;
        issue(v);
        wait_done(lat);
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_busy_at_done"}, o_busy, 0);
        check({tag, "_ack_err"}, o_ack_err, v.err);
        if (v.chk_rd) check({tag, "_rdata"}, o_rdata, v.rd);
        check({tag, "_bus_left"}, exp_q.size(), 0);
        check({tag, "_pins_released"}, {o_sda, o_scl}, 2'b11);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, o_done, 0);
        stretch_en = 1'b0;
    endtask

    initial begin
        vec_t va, vb, vr;
        int lat;
        tbl[0] = '{1'b0, 7'h76, 8'h49, 8'hC0, 1'b0, 464, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 7'h76, 8'h4B, 8'h00, 1'b0, 624, 1'b0, 1'b1, 8'h95};
        tbl[2] = '{1'b1, 7'h33, 8'h4B, 8'h00, 1'b0, 176, 1'b1, 1'b1, 8'h95};
        tbl[3] = '{1'b0, 7'h76, 8'h12, 8'h5A, 1'b1, 501, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 7'h33, 8'hA0, 8'h0F, 1'b0, 176, 1'b1, 1'b0, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_sda", o_sda, 1);
        check("reset_scl", o_scl, 1);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_ack_err", o_ack_err, 0);
        check("reset_rdata", o_rdata, 8'h00);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++)
            do_txn(tbl[i], $sformatf("vec%0d", i));

        // strobe while busy is ignored, strobe in the done cycle is taken
        va = '{1'b0, 7'h76, 8'h21, 8'h7E, 1'b0, 464, 1'b0, 1'b0, 8'h00};
        vb = '{1'b0, 7'h76, 8'h0F, 8'h81, 1'b0, 464, 1'b0, 1'b0, 8'h00};
        push_expected(va);
        issue(va);
        repeat (50) @(posedge clk);
        #1;
        i_start = 1'b1;
        i_rnw = 1'b1;
        i_dev_addr = 7'h33;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(lat);
        check("b2b_first_latency", lat, 464);
        check("b2b_first_ack_err", o_ack_err, 0);
        check("b2b_first_bus_left", exp_q.size(), 0);
        push_expected(vb);
        issue(vb);
        check("b2b_done_cleared", o_done, 0);
        wait_done(lat);
        check("b2b_second_latency", lat, 464);
        check("b2b_second_bus_left", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of the address byte
        vr = '{1'b0, 7'h76, 8'h5A, 8'h3C, 1'b0, 464, 1'b0, 1'b0, 8'h00};
        push_expected(vr);
        issue(vr);
        repeat (40) @(posedge clk);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (!o_scl && !o_sda) break;
        end
        check("pre_reset_pins_low", {o_sda, o_scl}, 2'b00);
        rst = 1'b1;
        #1;
        check("midrst_sda", o_sda, 1);
        check("midrst_scl", o_scl, 1);
        check("midrst_busy", o_busy, 0);
        check("midrst_rdata", o_rdata, 8'h00);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vr = '{1'b0, 7'h76, 8'h3C, 8'hA5, 1'b0, 464, 1'b0, 1'b0, 8'h00};
        do_txn(vr, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
